// File: rtl/contador_botoes.sv
`default_nettype none
// ============================================================================
// contador_botoes: two debounced pushbuttons driving a wrapping up/down counter
// Rev 1.0
// ============================================================================
module contador_botoes #(
   parameter int WIDTH           = 4,
   parameter int MAX_COUNT       = 15,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_up,
   input  logic             btn_down,
   output logic [WIDTH-1:0] count,
   output logic             up_pulse,
   output logic             down_pulse,
   output logic             wrap
);

   localparam int DC_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

   generate
      if (MAX_COUNT < 0 || MAX_COUNT > (2 ** WIDTH) - 1) begin : g_bad_max_count
         $error("contador_botoes: MAX_COUNT does not fit in WIDTH bits");
      end
      if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
         $error("contador_botoes: DEBOUNCE_CYCLES must be at least 2");
      end
   endgenerate

   // Index 0 is the up button, index 1 the down button.
   logic [1:0] raw;
   logic [1:0] press;

   assign raw = {btn_down, btn_up};

   generate
      for (genvar i = 0; i < 2; i++) begin : g_chan
         logic            sync1;
         logic            sync2;
         logic            st;
         logic [DC_W-1:0] dc;
         logic            accept;

         assign accept   = (sync2 != st) && (dc == DC_LAST);
         assign press[i] = accept && sync2;

         always_ff @(posedge clk) begin
            if (rst) begin
               sync1 <= 1'b0;
               sync2 <= 1'b0;
               st    <= 1'b0;
               dc    <= '0;
            end else begin
               sync1 <= raw[i];
               sync2 <= sync1;
               if (sync2 == st) begin
                  dc <= '0;
               end else if (accept) begin
                  st <= sync2;
                  dc <= '0;
               end else begin
                  dc <= dc + 1'b1;
               end
            end
         end
      end
   endgenerate

   logic [WIDTH-1:0] count_next;
   logic             wrap_next;

   always_comb begin
      count_next = count;
      wrap_next  = 1'b0;
      case (press)
         2'b01: begin
            if (count == MAX_VAL) begin
               count_next = '0;
               wrap_next  = 1'b1;
            end else begin
               count_next = count + 1'b1;
            end
         end
         2'b10: begin
            if (count == '0) begin
               count_next = MAX_VAL;
               wrap_next  = 1'b1;
            end else begin
               count_next = count - 1'b1;
            end
         end
         default: begin
            count_next = count;
            wrap_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         up_pulse   <= 1'b0;
         down_pulse <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         count      <= count_next;
         up_pulse   <= press[0];
         down_pulse <= press[1];
         wrap       <= wrap_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_contador_botoes.sv
`default_nettype none
// ============================================================================
// tb_contador_botoes: randomized bench with a scoreboard for contador_botoes
// Rev 1.0
// ============================================================================
module tb_contador_botoes;

   localparam int DEB  = 4;
   localparam int MAXC = 15;
   localparam int LOGN = 8192;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic [3:0] count;
   logic       up_pulse;
   logic       down_pulse;
   logic       wrap;

   int checks = 0;
   int failures = 0;

   contador_botoes #(
      .WIDTH(4),
      .MAX_COUNT(MAXC),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .count(count),
      .up_pulse(up_pulse),
      .down_pulse(down_pulse),
      .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       up;
      bit       dn;
      bit       wr;
      int       cnt;
      int       edge_n;
   } exp_t;

   exp_t exp_q[$];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
      end
   endtask

   // Reference model: the synchronized level is the raw level two edges late,
   // a level change is accepted after DEB consecutive disagreeing edges, and
   // an accepted 0->1 change is a press event.
   int cyc = 0;
   int post = 0;
   int m_count = 0;
   bit m_st [2];
   int run [2];
   bit log_s [2][LOGN];

   always @(posedge clk) begin
      bit raw_v [2];
      bit ev [2];
      bit synced;
      bit wr;
      cyc++;
      if (rst) begin
         post    = 0;
         m_count = 0;
         for (int b = 0; b < 2; b++) begin
            m_st[b] = 1'b0;
            run[b]  = 0;
         end
      end else begin
         raw_v[0] = btn_up;
         raw_v[1] = btn_down;
         for (int b = 0; b < 2; b++) begin
            synced = (post >= 2) ? log_s[b][(cyc - 2) % LOGN] : 1'b0;
            log_s[b][cyc % LOGN] = raw_v[b];
            ev[b] = 1'b0;
            if (synced != m_st[b]) begin
               run[b]++;
               if (run[b] == DEB) begin
                  m_st[b] = synced;
                  run[b]  = 0;
                  ev[b]   = synced;
               end
            end else begin
               run[b] = 0;
            end
         end
         post++;
         wr = 1'b0;
         if (ev[0] && !ev[1]) begin
            if (m_count == MAXC) begin m_count = 0; wr = 1'b1; end
            else m_count = m_count + 1;
         end else if (ev[1] && !ev[0]) begin
            if (m_count == 0) begin m_count = MAXC; wr = 1'b1; end
            else m_count = m_count - 1;
         end
         if (ev[0] || ev[1])
            exp_q.push_back('{up: ev[0], dn: ev[1], wr: wr, cnt: m_count, edge_n: cyc});
      end
   end

   // Monitor: samples just after each edge and retires scoreboard entries.
   always @(posedge clk) begin
      exp_t e;
      #1;
      chk("count", int'(count), m_count);
      if (up_pulse || down_pulse || wrap || (exp_q.size() > 0 && exp_q[0].edge_n <= cyc)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", int'({up_pulse, down_pulse, wrap}), 0);
         end else begin
            e = exp_q.pop_front();
            chk("event_edge", cyc, e.edge_n);
            chk("up_pulse", int'(up_pulse), int'(e.up));
            chk("down_pulse", int'(down_pulse), int'(e.dn));
            chk("wrap", int'(wrap), int'(e.wr));
            chk("event_count", int'(count), e.cnt);
         end
      end
   end

   task automatic drive(input logic u, input logic d, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         btn_up   = u;
         btn_down = d;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Reset then idle
      do_reset(2);
      drive(0, 0, 50);
      chk("idle_count", int'(count), 0);

      // Clean press, held, then released
      drive(1, 0, 20);
      drive(0, 0, 10);
      chk("after_clean_press", int'(count), 1);

      // Glitch too short, then just long enough
      drive(1, 0, 3);
      drive(0, 0, 10);
      chk("after_glitch", int'(count), 1);
      drive(1, 0, 5);
      drive(0, 0, 10);
      chk("after_5cycle_press", int'(count), 2);

      // Sixteen up presses from zero, then a down press at zero
      do_reset(2);
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 6);
         drive(0, 0, 6);
      end
      chk("after_16_ups", int'(count), 0);
      drive(0, 1, 6);
      drive(0, 0, 6);
      chk("after_down_at_zero", int'(count), 15);

      // Simultaneous presses at count 7
      do_reset(2);
      for (int i = 0; i < 7; i++) begin
         drive(1, 0, 6);
         drive(0, 0, 6);
      end
      drive(1, 1, 8);
      drive(0, 0, 8);
      chk("after_simultaneous", int'(count), 7);

      // Reset while a down debounce is in progress
      do_reset(2);
      drive(0, 1, 2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1, 12);
      drive(0, 0, 10);
      chk("after_reset_mid_debounce", int'(count), 15);

      // Randomized button activity with occasional resets
      for (int s = 0; s < 80; s++) begin
         if ($urandom_range(0, 24) == 0)
            do_reset(1);
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(1, 9)));
      end

      drive(0, 0, 15);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
